// File: rtl/prio_irq_encoder.sv
// Registered priority encoder for N active-low asynchronous request lines.
// Falling edges latch sticky pending bits; the highest index is shown with a valid/ack handshake.
module prio_irq_encoder #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         iClk,
    input  logic         iRst_n,
    input  logic [N-1:0] iReq,
    input  logic         iEI,
    input  logic         iAck,
    output logic [W-1:0] oCode,
    output logic         oValid,
    output logic         oEO,
    output logic         oLost
);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   s1_q, s2_q, s3_q;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   edge_v, clr;
    logic [2:0]     arm_q;
    logic [W-1:0]   code_q, code_d, sel;
    logic           lost_q, lost_d;
    logic           eo_q, eo_d;
    logic           ack_take;

    // Synchroniser plus edge history; idle-high so released lines never look like edges.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            s1_q  <= '1;
            s2_q  <= '1;
            s3_q  <= '1;
            arm_q <= '0;
        end else begin
            s1_q  <= iReq;
            s2_q  <= s1_q;
            s3_q  <= s2_q;
            arm_q <= {arm_q[1:0], 1'b1};
        end
    end

    // Edges are masked until the chain has refilled, so a line held low through reset is not a request.
    assign edge_v   = ~s2_q & s3_q & {N{arm_q[2]}};
    assign ack_take = (state_q == SHOW) && iAck;
    assign clr      = ack_take ? ({{(N-1){1'b0}}, 1'b1} << code_q) : '0;

    // Set wins over clear, so a re-request during the ack stays pending.
    assign pend_d = (pend_q & ~clr) | edge_v;
    assign lost_d = |(edge_v & pend_q & ~clr);
    assign eo_d   = ~iEI & ~|pend_q;

    always_comb begin
        sel = '0;
        for (int i = 0; i < N; i++) begin
            if (pend_q[i]) sel = W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                if (!iEI && |pend_q) begin
                    code_d  = sel;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                // Code stays frozen; no preemption by higher-priority arrivals.
                if (iAck || iEI) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            code_q  <= '0;
            pend_q  <= '0;
            lost_q  <= 1'b0;
            eo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            eo_q    <= eo_d;
        end
    end

    assign oCode  = code_q;
    assign oValid = (state_q == SHOW);
    assign oEO    = eo_q;
    assign oLost  = lost_q;

endmodule
